// File: rtl/floo_mcast_output_scheduler.sv
// floo_mcast_output_scheduler: round-robin owner selection for one router output.
// Holds a wormhole lock across multi-flit packets and keeps unaccepted offers stable.
// Optional starvation priority is enabled by defining FLOO_MCAST_SCHED_STARVE_EN.
module floo_mcast_output_scheduler #(
  parameter int unsigned NumReq    = 5,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxStarve = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             valid_i,
  output logic [NumReq-1:0]             ready_o,
  input  logic [NumReq*DataWidth-1:0]   data_i,
  input  logic [NumReq-1:0]             last_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DataWidth-1:0]          data_o,
  output logic                          last_o,
  output logic [$clog2(NumReq)-1:0]     gnt_idx_o,
  output logic                          locked_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] rr_idx, win_idx, offer_idx;
  logic            rr_found, any_valid, offer_valid, offer_last, hs;

  assign any_valid = |valid_i;

  // Round-robin scan starting just after the last-served requester.
  always_comb begin
    int unsigned cand;
    rr_idx   = ptr_q;
    rr_found = 1'b0;
    cand     = 0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!rr_found && valid_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(cand);
      end
    end
  end

`ifdef FLOO_MCAST_SCHED_STARVE_EN
  localparam int unsigned AgeW = $clog2(MaxStarve + 1);

  logic [AgeW-1:0] age_q [NumReq];
  logic            starve_found;
  logic [IdxW-1:0] starve_idx;

  // Lowest-index waiting requester whose age has saturated overrides round-robin.
  always_comb begin
    starve_found = 1'b0;
    starve_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!starve_found && valid_i[k] && (age_q[k] == AgeW'(MaxStarve))) begin
        starve_found = 1'b1;
        starve_idx   = IdxW'(k);
      end
    end
  end

  assign win_idx = starve_found ? starve_idx : rr_idx;

  // Ages count cycles spent waiting; they saturate and clear on accept or withdrawal.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NumReq; k++) age_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (!valid_i[k] || ready_o[k]) age_q[k] <= '0;
        else if (age_q[k] != AgeW'(MaxStarve)) age_q[k] <= age_q[k] + AgeW'(1);
      end
    end
  end
`else
  logic unused_max_starve;
  assign unused_max_starve = (MaxStarve != 0);
  assign win_idx = rr_idx;
`endif

  // Owner selection and next-state decode; only the owner is visible outside IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    offer_valid = 1'b0;
    offer_idx   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          offer_valid = 1'b1;
          offer_idx   = win_idx;
        end
      end
      HOLD, LOCKED: begin
        offer_valid = valid_i[sel_q];
        offer_idx   = sel_q;
      end
      default: ;
    endcase
    if (rst_i) begin
      offer_valid = 1'b0;
      offer_idx   = '0;
    end
    offer_last = last_i[offer_idx];
    hs         = offer_valid & ready_i;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (hs && offer_last) begin
            ptr_d = win_idx;
          end else begin
            state_d = hs ? LOCKED : HOLD;
            sel_d   = win_idx;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          if (offer_last) begin
            state_d = IDLE;
            ptr_d   = sel_q;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (hs && offer_last) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux; data and tail flag read as zero whenever nothing is offered.
  always_comb begin
    valid_o   = offer_valid;
    gnt_idx_o = offer_idx;
    data_o    = offer_valid ? data_i[offer_idx*DataWidth +: DataWidth] : '0;
    last_o    = offer_valid & offer_last;
    locked_o  = (state_q != IDLE) & ~rst_i;
    ready_o   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      ready_o[k] = hs & (offer_idx == IdxW'(k));
    end
  end

  // State register; reset makes requester 0 the first round-robin winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IdxW'(NumReq - 1);
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  hold_offer_kept: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD) |-> valid_i[sel_q]);

endmodule
